// File: rtl/anton_neopixel_bus_scheduler_pkg.sv
// Shared constants, state encoding and bus command payload for the neopixel bus scheduler.
package anton_neopixel_bus_scheduler_pkg;

  localparam int unsigned NPORT      = 2;
  localparam int unsigned ADDR_W     = 14;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned MAX_W      = 13;
  localparam int unsigned CFG_W      = 3;
  localparam int unsigned REGSEL_BIT = 13;

  localparam logic [ADDR_W-1:0] REG_MAX_LO = 14'h2000;
  localparam logic [ADDR_W-1:0] REG_MAX_HI = 14'h2001;
  localparam logic [ADDR_W-1:0] REG_CTRL   = 14'h2002;

  localparam int unsigned CTRL_LIMIT_BIT = 1;
  localparam int unsigned CTRL_RUN_BIT   = 2;
  localparam int unsigned CTRL_LOOP_BIT  = 3;
  localparam int unsigned CTRL_32BIT_BIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_CFG_LO   = 3'd2,
    ST_CFG_HI   = 3'd3,
    ST_CFG_CTRL = 3'd4
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              write;
    logic              read;
  } bus_cmd_t;

  // CTRL register image for a commit: cfg = {ctrl32bit, loop, limit}, run always set.
  function automatic logic [DATA_W-1:0] ctrl_byte(input logic [CFG_W-1:0] cfg);
    logic [DATA_W-1:0] b;
    b                 = '0;
    b[CTRL_LIMIT_BIT] = cfg[0];
    b[CTRL_RUN_BIT]   = 1'b1;
    b[CTRL_LOOP_BIT]  = cfg[1];
    b[CTRL_32BIT_BIT] = cfg[2];
    return b;
  endfunction

endpackage

// File: rtl/anton_neopixel_bus_scheduler_rr_arbiter2.sv
// Two-port round-robin grant: one-hot grant from an eligibility mask, pointer moves past the winner.
module anton_neopixel_bus_scheduler_rr_arbiter2
  import anton_neopixel_bus_scheduler_pkg::*;
(
  input  logic [NPORT-1:0] elig_i,
  input  logic             rr_ptr_i,
  input  logic             accept_i,
  output logic [NPORT-1:0] grant_o,
  output logic             rr_ptr_next_o
);

  logic gidx;

  always_comb begin
    gidx          = (elig_i == 2'b11) ? rr_ptr_i : elig_i[1];
    grant_o       = '0;
    rr_ptr_next_o = rr_ptr_i;
    if (|elig_i) begin
      grant_o[gidx] = 1'b1;
      if (accept_i) rr_ptr_next_o = ~gidx;
    end
  end

endmodule

// File: rtl/anton_neopixel_bus_scheduler.sv
// Arbitrates two masters onto the neopixel core byte bus, sequences frame commits
// and tracks the frame through pixelsSync with a timeout and pixel-buffer tear guard.
module anton_neopixel_bus_scheduler
  import anton_neopixel_bus_scheduler_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 700000,
  parameter bit          TEAR_GUARD   = 1'b1
) (
  input  logic                    busClk,
  input  logic                    busReset,
  input  logic [NPORT-1:0]        reqValid,
  input  logic [NPORT-1:0]        reqWrite,
  input  logic [NPORT*ADDR_W-1:0] reqAddr,
  input  logic [NPORT*DATA_W-1:0] reqData,
  output logic [NPORT-1:0]        reqReady,
  output logic [NPORT-1:0]        rspValid,
  output logic [DATA_W-1:0]       rspData,
  input  logic                    commitValid,
  input  logic [MAX_W-1:0]        commitMax,
  input  logic [CFG_W-1:0]        commitCfg,
  output logic                    commitReady,
  output logic                    frameActive,
  output logic                    frameDone,
  output logic                    timeoutErr,
  output logic [ADDR_W-1:0]       busAddr,
  output logic [DATA_W-1:0]       busDataIn,
  output logic                    busWrite,
  output logic                    busRead,
  input  logic [DATA_W-1:0]       busDataOut,
  input  logic                    pixelsSync
);

  localparam int unsigned CNT_W = $clog2(SYNC_TIMEOUT + 1);

  state_e            state_q, state_d;
  bus_cmd_t          cmd_q, cmd_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              owner_q, owner_d;
  logic [NPORT-1:0]  rsp_valid_q, rsp_valid_d;
  logic [MAX_W-1:0]  max_q, max_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic              frame_active_q, frame_active_d;
  logic              frame_done_q, frame_done_d;
  logic              timeout_err_q, timeout_err_d;
  logic              sync_q;
  logic              armed_q, armed_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              guard;
  logic [NPORT-1:0]  elig;
  logic [NPORT-1:0]  grant;
  logic              gsel;
  logic              commit_fire;
  logic              req_accept;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] data_sel;
  logic              sync_fall;
  logic              done_hit;
  logic              tmo_hit;

  // Reads and register-file writes always pass; buffer writes wait out an active frame.
  assign guard   = TEAR_GUARD & frame_active_q;
  assign elig[0] = reqValid[0] & ~(guard & reqWrite[0] & ~reqAddr[REGSEL_BIT]);
  assign elig[1] = reqValid[1] & ~(guard & reqWrite[1] & ~reqAddr[ADDR_W + REGSEL_BIT]);

  assign commitReady = (state_q == ST_IDLE) & ~frame_active_q;
  assign commit_fire = commitValid & commitReady;
  assign req_accept  = (state_q == ST_IDLE) & ~commit_fire & (|elig);

  anton_neopixel_bus_scheduler_rr_arbiter2 u_arb (
    .elig_i        (elig),
    .rr_ptr_i      (rr_ptr_q),
    .accept_i      (req_accept),
    .grant_o       (grant),
    .rr_ptr_next_o (rr_ptr_d)
  );

  assign gsel     = grant[1];
  assign addr_sel = gsel ? reqAddr[2*ADDR_W-1:ADDR_W] : reqAddr[ADDR_W-1:0];
  assign data_sel = gsel ? reqData[2*DATA_W-1:DATA_W] : reqData[DATA_W-1:0];

  // Next-state and next bus command; commands are computed one cycle ahead of the bus.
  always_comb begin
    state_d     = state_q;
    cmd_d       = '0;
    rsp_valid_d = '0;
    owner_d     = owner_q;
    max_d       = max_q;
    cfg_d       = cfg_q;
    unique case (state_q)
      ST_IDLE: begin
        if (commit_fire) begin
          max_d       = commitMax;
          cfg_d       = commitCfg;
          cmd_d.addr  = REG_MAX_LO;
          cmd_d.data  = commitMax[7:0];
          cmd_d.write = 1'b1;
          state_d     = ST_CFG_LO;
        end else if (req_accept) begin
          cmd_d.addr = addr_sel;
          if (reqWrite[gsel]) begin
            cmd_d.data  = data_sel;
            cmd_d.write = 1'b1;
          end else begin
            cmd_d.read = 1'b1;
            owner_d    = gsel;
            state_d    = ST_RD;
          end
        end
      end
      ST_RD: begin
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = ST_IDLE;
      end
      ST_CFG_LO: begin
        cmd_d.addr  = REG_MAX_HI;
        cmd_d.data  = {3'b000, max_q[12:8]};
        cmd_d.write = 1'b1;
        state_d     = ST_CFG_HI;
      end
      ST_CFG_HI: begin
        cmd_d.addr  = REG_CTRL;
        cmd_d.data  = ctrl_byte(cfg_q);
        cmd_d.write = 1'b1;
        state_d     = ST_CFG_CTRL;
      end
      ST_CFG_CTRL: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign sync_fall = sync_q & ~pixelsSync;
  assign done_hit  = frame_active_q & armed_q & sync_fall;
  assign tmo_hit   = frame_active_q & (cnt_q == CNT_W'(SYNC_TIMEOUT - 1));

  // Frame tracking; a sync fall only counts once sync has been seen low in this frame.
  always_comb begin
    frame_active_d = frame_active_q;
    frame_done_d   = 1'b0;
    timeout_err_d  = timeout_err_q;
    armed_d        = armed_q;
    cnt_d          = cnt_q;
    if (commit_fire) begin
      frame_active_d = 1'b1;
      timeout_err_d  = 1'b0;
      cnt_d          = '0;
      armed_d        = ~pixelsSync;
    end else if (frame_active_q) begin
      if (!pixelsSync) armed_d = 1'b1;
      if (cnt_q != CNT_W'(SYNC_TIMEOUT)) cnt_d = cnt_q + CNT_W'(1);
      if (done_hit) begin
        frame_done_d   = 1'b1;
        frame_active_d = 1'b0;
      end else if (tmo_hit) begin
        timeout_err_d  = 1'b1;
        frame_active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge busClk or posedge busReset) begin
    if (busReset) begin
      state_q        <= ST_IDLE;
      cmd_q          <= '0;
      rr_ptr_q       <= 1'b0;
      owner_q        <= 1'b0;
      rsp_valid_q    <= '0;
      max_q          <= '0;
      cfg_q          <= '0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      timeout_err_q  <= 1'b0;
      sync_q         <= 1'b0;
      armed_q        <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      rr_ptr_q       <= rr_ptr_d;
      owner_q        <= owner_d;
      rsp_valid_q    <= rsp_valid_d;
      max_q          <= max_d;
      cfg_q          <= cfg_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
      timeout_err_q  <= timeout_err_d;
      sync_q         <= pixelsSync;
      armed_q        <= armed_d;
      cnt_q          <= cnt_d;
    end
  end

  // Core read data is already registered, so it is forwarded alongside the strobe.
  assign reqReady    = req_accept ? grant : '0;
  assign rspValid    = rsp_valid_q;
  assign rspData     = (|rsp_valid_q) ? busDataOut : '0;
  assign frameActive = frame_active_q;
  assign frameDone   = frame_done_q;
  assign timeoutErr  = timeout_err_q;
  assign busAddr     = cmd_q.addr;
  assign busDataIn   = cmd_q.data;
  assign busWrite    = cmd_q.write;
  assign busRead     = cmd_q.read;

endmodule

// File: doc/anton_neopixel_bus_scheduler.md
Name: anton_neopixel_bus_scheduler

Overview:
Sits between two bus masters (host port 0, animation engine port 1) and the single byte-wide pixel/register bus of the neopixel raw core. It arbitrates single-byte read and write transactions round-robin. It sequences frame commits: MAX low byte, MAX high byte, then CTRL with run set. It tracks the frame through pixelsSync and guards the pixel buffer against tearing while a frame streams.

Parameters:
SYNC_TIMEOUT, 20'd700000, busClk cycles allowed from commit to pixelsSync fall before abort (~100 ms at 7 MHz)
TEAR_GUARD, 1, 1 = pixel-buffer writes (addr[13]==0) are held off while a frame is active; 0 = no guard

Ports:
busClk  in  1  bus clock; all logic on rising edge
busReset  in  1  asynchronous, active-high reset
reqValid  in  2  per-port transaction request
reqWrite  in  2  per-port 1 = write, 0 = read
reqAddr  in  28  port i at [14i+13:14i]; bit13 = 1 selects the register file
reqData  in  16  port i write data at [8i+7:8i]
reqReady  out  2  combinational grant; transfer happens when valid & ready
rspValid  out  2  one-cycle read-data strobe to the owning port
rspData  out  8  read data, valid with rspValid
commitValid  in  1  frame commit request
commitMax  in  13  value written to REG_MAX
commitCfg  in  3  {ctrl32bit, loop, limit}
commitReady  out  1  commit accepted when valid & ready
frameActive  out  1  high from commit acceptance to end of frame
frameDone  out  1  one-cycle pulse on pixelsSync falling edge while frameActive
timeoutErr  out  1  sticky; set on SYNC_TIMEOUT expiry
busAddr  out  14  to core bus address
busDataIn  out  8  to core write data
busWrite  out  1  to core write strobe
busRead  out  1  to core read strobe
busDataOut  in  8  from core registered read data
pixelsSync  in  1  from core; high during the reset/latch gap

Behaviour:
- Reset: state IDLE; rrPtr=0; all outputs 0; frameActive=0; timeoutErr=0; sync edge register=0. Assertion mid-transaction drops busWrite/busRead immediately. Any in-flight read is lost and returns no rspValid.
- Bus outputs are registered. A transfer accepted in cycle T drives busAddr/busDataIn/busWrite or busRead for exactly one cycle, T+1.
- FSM states: IDLE, RD, CFG_LO, CFG_HI, CFG_CTRL.
- IDLE priority: commit first, then requests.
  - commitReady = IDLE & !frameActive. Commit wins over any request in the same cycle; reqReady=0 that cycle.
  - Port i is eligible if reqValid[i] and not (TEAR_GUARD & frameActive & reqWrite[i] & !reqAddr[14i+13]). Reads are never guarded.
  - Both ports eligible: grant port rrPtr, then rrPtr <= ~granted. One eligible: grant it; rrPtr <= ~granted.
  - reqReady is at most one-hot.
- Write: launched at T+1; FSM stays in IDLE, so back-to-back writes run 1 per cycle.
- Read: IDLE->RD at T+1 with busRead high. RD->IDLE at T+2; rspValid[owner] pulses at T+2 with rspData=busDataOut. A new accept is possible at T+2. No reqReady during RD.
- Commit accepted at T:
  - CFG_LO (T+1): write 0x2000 <- commitMax[7:0]
  - CFG_HI (T+2): write 0x2001 <- {3'b0, commitMax[12:8]}
  - CFG_CTRL (T+3): write 0x2002 <- {3'b0, cfg32bit, loop, 1'b1, limit, 1'b0}
  - IDLE at T+4. Commit fields are latched at T.
  - frameActive=1 from T+1; timeoutErr cleared at T+1; timeout counter cleared.
- Frame tracking: pixelsSync is used directly (same clock domain). The falling edge is detected with a 1-cycle delayed copy. First pixelsSync fall while frameActive -> frameDone pulse, frameActive=0. A pixelsSync already high at commit must be ignored until it has gone low once (edge arming).
- Timeout: the counter increments each cycle while frameActive and saturates at SYNC_TIMEOUT. On reaching it: timeoutErr=1, frameActive=0, no frameDone.
- Sync fall and timeout in the same cycle: frameDone wins; timeoutErr stays 0.
- Widths: counter is CLOG2(SYNC_TIMEOUT+1) bits. Address and data are passed through unchanged.

Decomposition:
- anton_common.vh: REG_MAX_LO 14'h2000, REG_MAX_HI 14'h2001, REG_CTRL 14'h2002, REG_STATE 14'h2003, ctrl bit positions, FSM state encodings.
- Sub-module anton_rr_arbiter2: eligibility mask + rrPtr in, one-hot grant out, pointer update on accept.

Test Plan:
- Port 0 write 0x0005<-0xAA, then port 1 read 0x0005 -> busWrite at T+1; busRead one cycle; rspValid[1] at T+2 with rspData=0xAA; rspValid[0] stays 0.
- Both ports request continuously with writes -> grants alternate 0,1,0,1; one busWrite every cycle; no starvation over 16 transfers.
- Commit commitMax=13'h013B, cfg=3'b000 -> writes 0x2000<-0x3B, 0x2001<-0x01, 0x2002<-0x04 on consecutive cycles; frameActive=1.
- During frameActive, TEAR_GUARD=1: port 0 buffer write is held (reqReady[0]=0), a port 1 register read is granted; after pixelsSync 1->0, frameDone pulses and the held write issues next cycle.
- Commit with pixelsSync stuck low, SYNC_TIMEOUT=100 -> timeoutErr=1 at cycle 100; frameActive=0; the next commit clears timeoutErr.
- busReset asserted during CFG_HI -> busWrite drops immediately; after release: IDLE, no stray CTRL write, all outputs 0.
